// File: rtl/uart_tx_if.sv
// Byte-write / serial-status bundle between a producer and the uart_tx block.
interface uart_tx_if;
  logic [7:0] datain;
  logic       wrsig;
  logic       tx;
  logic       busy;
  logic       full;
  logic       overflow;
  logic       txdone;

  modport master (
    output datain, wrsig,
    input  tx, busy, full, overflow, txdone
  );

  modport slave (
    input  datain, wrsig,
    output tx, busy, full, overflow, txdone
  );
endinterface

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start, 8 data bits LSB first, parity, stop.
// A one-entry holding register lets a second byte queue behind the frame in flight.
module uart_tx #(
  parameter logic        PARITYMODE = 1'b0,
  parameter int unsigned BITCLKS    = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int unsigned CNT_W    = (BITCLKS > 1) ? $clog2(BITCLKS) : 1;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned BYTE_W   = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITCLKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(7);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [IDX_W-1:0]    idx, idx_nx;
  logic [BYTE_W-1:0]   shift, shift_nx;
  logic                par, par_nx;
  logic [BYTE_W-1:0]   hold, hold_nx;
  logic                full_q, full_nx;
  logic                tx_q, tx_nx;
  logic                busy_q, busy_nx;
  logic                overflow_q, overflow_nx;
  logic                txdone_q, txdone_nx;
  logic                bit_end;
  logic                drain;

  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.full     = full_q;
  assign bus.overflow = overflow_q;
  assign bus.txdone   = txdone_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    idx_nx      = idx;
    shift_nx    = shift;
    par_nx      = par;
    hold_nx     = hold;
    full_nx     = full_q;
    overflow_nx = 1'b0;
    tx_nx       = 1'b1;
    drain       = 1'b0;
    bit_end     = (cnt == CNT_LAST);

    if (state != IDLE) begin
      cnt_nx = bit_end ? '0 : cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (full_q) begin
          drain = 1'b1;
        end else if (bus.wrsig) begin
          shift_nx = bus.datain;
          par_nx   = PARITYMODE ^ (^bus.datain);
          state_nx = START;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nx = DATA;
          idx_nx   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          idx_nx = idx + 1'b1;
          if (idx == IDX_LAST) begin
            state_nx = PARITY;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nx = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (full_q) begin
            drain = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // A drain frees the holding slot in the same cycle, so a concurrent write refills it.
    if (drain) begin
      shift_nx = hold;
      par_nx   = PARITYMODE ^ (^hold);
      state_nx = START;
      cnt_nx   = '0;
      idx_nx   = '0;
      full_nx  = bus.wrsig;
      if (bus.wrsig) begin
        hold_nx = bus.datain;
      end
    end else if (bus.wrsig && (state != IDLE)) begin
      if (!full_q) begin
        hold_nx = bus.datain;
        full_nx = 1'b1;
      end else begin
        overflow_nx = 1'b1;
      end
    end

    // Line level follows the state being entered so tx is a clean flop output.
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[idx_nx];
      PARITY:  tx_nx = par_nx;
      default: tx_nx = 1'b1;
    endcase

    busy_nx   = (state_nx != IDLE);
    txdone_nx = (state_nx == STOP) && (cnt_nx == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      par        <= 1'b0;
      full_q     <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      txdone_q   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      shift      <= shift_nx;
      par        <= par_nx;
      full_q     <= full_nx;
      tx_q       <= tx_nx;
      busy_q     <= busy_nx;
      overflow_q <= overflow_nx;
      txdone_q   <= txdone_nx;
    end
  end

  // Holding contents are only meaningful while full is set, so no reset needed.
  always_ff @(posedge clk) begin
    hold <= hold_nx;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised scoreboard bench for uart_tx: a cycle-level timing model predicts
// accepted bytes, frame end times and status flags; monitors decode the line.
module tb_uart_tx;
  localparam int unsigned B     = 16;
  localparam int unsigned FRAME = 11 * B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if bus ();
  uart_tx_if bus_o ();

  uart_tx #(.PARITYMODE(1'b0), .BITCLKS(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  uart_tx #(.PARITYMODE(1'b1), .BITCLKS(B)) dut_odd (
    .clk (clk),
    .rst (rst),
    .bus (bus_o.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Reference model state
  int         m_end = -1;
  bit         m_pend = 1'b0;
  logic [7:0] byte_q[$];
  int         txd_q[$];
  logic       exp_busy = 1'b0, exp_full = 1'b0, exp_ovf = 1'b0;
  int         ovf_exp = 0, ovf_seen = 0, frames = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic even_par(input logic [7:0] b);
    return logic'($countones(b) % 2);
  endfunction

  // One clock of stimulus; the model decides the fate of the offered byte.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    int c;
    logic ovf_n;
    bus.wrsig  = w;
    bus.datain = d;
    rst        = r;
    c          = cyc;
    ovf_n      = 1'b0;
    if (r) begin
      m_end  = c;
      m_pend = 1'b0;
    end else if (m_pend && c >= m_end) begin
      m_end = c + int'(FRAME);
      txd_q.push_back(m_end);
      m_pend = w;
      if (w) byte_q.push_back(d);
    end else if (w) begin
      if (!m_pend && c > m_end) begin
        m_end = c + int'(FRAME);
        txd_q.push_back(m_end);
        byte_q.push_back(d);
      end else if (!m_pend) begin
        m_pend = 1'b1;
        byte_q.push_back(d);
      end else begin
        ovf_n = 1'b1;
        ovf_exp++;
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      byte_q.delete();
      txd_q.delete();
    end
    exp_busy  = (c + 1 <= m_end);
    exp_full  = m_pend;
    exp_ovf   = ovf_n;
    bus.wrsig = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
  endtask

  // Status-flag and txdone scoreboard
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("full", 32'(bus.full), 32'(exp_full));
      chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
      if (bus.overflow === 1'b1) ovf_seen++;
      if (txd_q.size() > 0 && txd_q[0] < cyc) begin
        chk("txdone_missed", 32'(0), 32'(1));
        void'(txd_q.pop_front());
      end
      if (bus.txdone === 1'b1) begin
        if (txd_q.size() == 0) chk("txdone_unexpected", 32'(1), 32'(0));
        else                   chk("txdone_cycle", 32'(cyc), 32'(txd_q.pop_front()));
      end
    end
  end

  // Line decoder: checks every cycle of a frame against the expected bit
  int          k = 0, glitch = 0;
  bit          in_frame = 1'b0, have_exp = 1'b0;
  logic [7:0]  eb = '0;
  logic [10:0] ebits = '0, rbits = '0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else if (chk_en) begin
      if (!in_frame && bus.tx === 1'b0) begin
        in_frame = 1'b1;
        k        = 0;
        glitch   = 0;
        have_exp = (byte_q.size() > 0);
        eb       = have_exp ? byte_q[0] : 8'h00;
        ebits    = {1'b1, even_par(eb), eb, 1'b0};
      end
      if (in_frame) begin
        if (bus.tx !== ebits[k / int'(B)]) glitch++;
        if (k % int'(B) == int'(B / 2)) rbits[k / int'(B)] = bus.tx;
        if (k == int'(FRAME) - 1) begin
          if (!have_exp) begin
            chk("frame_unexpected", 32'(1), 32'(0));
          end else begin
            void'(byte_q.pop_front());
            chk("rx_data", 32'(rbits[8:1]), 32'(eb));
            chk("rx_parity", 32'(rbits[9]), 32'(even_par(eb)));
            chk("rx_start", 32'(rbits[0]), 32'(0));
            chk("rx_stop", 32'(rbits[10]), 32'(1));
            chk("bit_timing", 32'(glitch), 32'(0));
            frames++;
          end
          in_frame = 1'b0;
        end else begin
          k++;
        end
      end
    end
  end

  initial begin
    bus.wrsig    = 1'b0;
    bus.datain   = 8'h00;
    bus_o.wrsig  = 1'b0;
    bus_o.datain = 8'h00;

    repeat (3) step(1'b0, 8'hA5, 1'b1);
    chk_en = 1'b1;
    chk("reset_tx", 32'(bus.tx), 32'(1));
    chk("reset_busy", 32'(bus.busy), 32'(0));
    chk("reset_full", 32'(bus.full), 32'(0));
    chk("reset_overflow", 32'(bus.overflow), 32'(0));
    chk("reset_txdone", 32'(bus.txdone), 32'(0));
    chk("reset_tx_odd", 32'(bus_o.tx), 32'(1));

    // 0x01 into even and odd parity instances together
    bus_o.wrsig  = 1'b1;
    bus_o.datain = 8'h01;
    step(1'b1, 8'h01, 1'b0);
    bus_o.wrsig  = 1'b0;
    for (int n = 0; n < 180; n++) begin
      if (n == 9 * int'(B) + int'(B / 2)) begin
        chk("parity_even_0x01", 32'(bus.tx), 32'(1));
        chk("parity_odd_0x01", 32'(bus_o.tx), 32'(0));
      end
      if (n == 10 * int'(B) + int'(B / 2)) chk("stop_odd", 32'(bus_o.tx), 32'(1));
      step(1'b0, 8'($urandom), 1'b0);
    end

    // Single 0x55 frame
    step(1'b1, 8'h55, 1'b0);
    idle(180);

    // Queued second byte goes out back-to-back
    step(1'b1, 8'hA3, 1'b0);
    idle(4);
    step(1'b1, 8'h3C, 1'b0);
    idle(370);

    // Third write while holding is occupied is dropped
    step(1'b1, 8'h11, 1'b0);
    idle(3);
    step(1'b1, 8'h22, 1'b0);
    idle(3);
    step(1'b1, 8'h33, 1'b0);
    idle(360);

    // Reset mid-frame, then a fresh frame
    step(1'b1, 8'hFF, 1'b0);
    idle(49);
    step(1'b0, 8'h00, 1'b1);
    chk("midreset_tx", 32'(bus.tx), 32'(1));
    chk("midreset_busy", 32'(bus.busy), 32'(0));
    idle(9);
    step(1'b1, 8'h00, 1'b0);
    idle(180);

    // Every byte value, random spacing, random extra writes that may be dropped
    for (int v = 0; v < 256; v++) begin
      idle(int'($urandom_range(0, 3)));
      for (int w = 0; w < 400 && m_pend; w++) idle(1);
      step(1'b1, 8'(v), 1'b0);
      if ($urandom_range(0, 3) == 0) step(1'b1, 8'($urandom), 1'b0);
    end

    for (int w = 0; w < 800 && cyc <= m_end + 5; w++) idle(1);
    idle(4);

    chk("bytes_outstanding", 32'(byte_q.size()), 32'(0));
    chk("txdone_outstanding", 32'(txd_q.size()), 32'(0));
    chk("overflow_count", 32'(ovf_seen), 32'(ovf_exp));
    chk("frames_min", 32'(frames >= 262), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
